// File: rtl/wb_write_queue.sv
// In-order writeback queue feeding the register file write port, with youngest-match forwarding.
// Optional build macro WBQ_R0_DROP_EN: discard writes to register 0 and never forward register 0.
module wb_write_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 16,
   parameter int unsigned AW    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alu_valid,
   input  logic [AW-1:0]            alu_reg,
   input  logic [DW-1:0]            alu_data,
   input  logic                     ld_valid,
   input  logic [AW-1:0]            ld_reg,
   input  logic [DW-1:0]            ld_data,
   output logic                     in_ready,
   output logic [AW-1:0]            DstReg,
   output logic                     WriteReg,
   output logic [DW-1:0]            DstData,
   input  logic [AW-1:0]            SrcReg1,
   input  logic [AW-1:0]            SrcReg2,
   output logic                     fwd_hit1,
   output logic [DW-1:0]            fwd_data1,
   output logic                     fwd_hit2,
   output logic [DW-1:0]            fwd_data2,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     err_ovf
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0] regMem  [DEPTH];
   logic [DW-1:0] dataMem [DEPTH];

   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] ldSlot;
   logic [PW-1:0] idx;
   logic          aluOk;
   logic          ldOk;
   logic          doPop;
   logic [CW-1:0] pushCnt;

`ifdef WBQ_R0_DROP_EN
   assign aluOk = alu_valid && (alu_reg != '0);
   assign ldOk  = ld_valid  && (ld_reg  != '0);
`else
   assign aluOk = alu_valid;
   assign ldOk  = ld_valid;
`endif

   // Readiness uses the registered count only; a same-cycle pop is not credited.
   assign in_ready = (count <= CW'(DEPTH - 2));
   assign doPop    = (count != '0);

   always_comb begin
      pushCnt = '0;
      if (in_ready) begin
         pushCnt = CW'(aluOk) + CW'(ldOk);
      end
      ldSlot = aluOk ? wrPtr + PW'(1) : wrPtr;
   end

   always_ff @(posedge clk) begin
      if (in_ready) begin
         if (aluOk) begin
            regMem[wrPtr]  <= alu_reg;
            dataMem[wrPtr] <= alu_data;
         end
         if (ldOk) begin
            regMem[ldSlot]  <= ld_reg;
            dataMem[ldSlot] <= ld_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         count   <= '0;
         err_ovf <= 1'b0;
      end else begin
         if (!in_ready && (aluOk || ldOk)) begin
            err_ovf <= 1'b1;
         end
         wrPtr <= wrPtr + pushCnt[PW-1:0];
         if (doPop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         count <= count + pushCnt - CW'(doPop);
      end
   end

   always_comb begin
      WriteReg = doPop;
      DstReg   = doPop ? regMem[rdPtr]  : '0;
      DstData  = doPop ? dataMem[rdPtr] : '0;
   end

   // Scan oldest to youngest so the last match (youngest) wins.
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      idx       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rdPtr + PW'(i);
         if (CW'(i) < count) begin
            if (regMem[idx] == SrcReg1) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = dataMem[idx];
            end
            if (regMem[idx] == SrcReg2) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = dataMem[idx];
            end
         end
      end
`ifdef WBQ_R0_DROP_EN
      if (SrcReg1 == '0) begin
         fwd_hit1  = 1'b0;
         fwd_data1 = '0;
      end
      if (SrcReg2 == '0) begin
         fwd_hit2  = 1'b0;
         fwd_data2 = '0;
      end
`endif
   end

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-based reference model plus a write-port scoreboard monitor.
module tb_wb_write_queue;

   localparam int DEPTH = 4;
`ifdef WBQ_R0_DROP_EN
   localparam bit R0DROP = 1'b1;
`else
   localparam bit R0DROP = 1'b0;
`endif

   typedef struct {
      logic [3:0]  r;
      logic [15:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        alu_valid = 1'b0;
   logic [3:0]  alu_reg = '0;
   logic [15:0] alu_data = '0;
   logic        ld_valid = 1'b0;
   logic [3:0]  ld_reg = '0;
   logic [15:0] ld_data = '0;
   logic        in_ready;
   logic [3:0]  DstReg;
   logic        WriteReg;
   logic [15:0] DstData;
   logic [3:0]  SrcReg1 = '0;
   logic [3:0]  SrcReg2 = '0;
   logic        fwd_hit1;
   logic [15:0] fwd_data1;
   logic        fwd_hit2;
   logic [15:0] fwd_data2;
   logic [2:0]  count;
   logic        err_ovf;

   ent_t modelQ[$];
   ent_t sbQ[$];
   bit   modelOvf = 1'b0;
   int   nCmp = 0;
   int   nErr = 0;

   wb_write_queue #(.DEPTH(4), .DW(16), .AW(4)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data),
      .in_ready(in_ready),
      .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData),
      .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
      .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
      .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
      .count(count), .err_ovf(err_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic bit keep(input logic v, input logic [3:0] r);
      return v && !(R0DROP && r == 4'd0);
   endfunction

   // Youngest pending entry for a register, searched from the tail of the model queue.
   task automatic lookup(input logic [3:0] src, output logic hit, output logic [15:0] data);
      hit  = 1'b0;
      data = '0;
      if (!(R0DROP && src == 4'd0)) begin
         for (int i = modelQ.size() - 1; i >= 0; i--) begin
            if (modelQ[i].r == src) begin
               hit  = 1'b1;
               data = modelQ[i].d;
               break;
            end
         end
      end
   endtask

   task automatic checkState();
      logic        h;
      logic [15:0] d;
      int          sz;
      sz = modelQ.size();
      chk("count", 32'(count), 32'(sz));
      chk("in_ready", 32'(in_ready), 32'((DEPTH - sz) >= 2));
      chk("err_ovf", 32'(err_ovf), 32'(modelOvf));
      chk("WriteReg", 32'(WriteReg), 32'(sz > 0));
      if (sz == 0) begin
         chk("idle_DstReg", 32'(DstReg), 32'd0);
         chk("idle_DstData", 32'(DstData), 32'd0);
      end
      lookup(SrcReg1, h, d);
      chk("fwd_hit1", 32'(fwd_hit1), 32'(h));
      chk("fwd_data1", 32'(fwd_data1), 32'(d));
      lookup(SrcReg2, h, d);
      chk("fwd_hit2", 32'(fwd_hit2), 32'(h));
      chk("fwd_data2", 32'(fwd_data2), 32'(d));
   endtask

   task automatic cycle(input bit rstN,
                        input bit av, input logic [3:0] ar, input logic [15:0] ad,
                        input bit lv, input logic [3:0] lr, input logic [15:0] ld,
                        input logic [3:0] s1, input logic [3:0] s2);
      bit   ready;
      bit   aOk;
      bit   lOk;
      ent_t e;
      rst = rstN;
      alu_valid = av; alu_reg = ar; alu_data = ad;
      ld_valid = lv;  ld_reg = lr;  ld_data = ld;
      SrcReg1 = s1;   SrcReg2 = s2;
      @(posedge clk);
      if (!rstN) begin
         modelQ.delete();
         sbQ.delete();
         modelOvf = 1'b0;
      end else begin
         ready = (DEPTH - modelQ.size()) >= 2;
         aOk = keep(av, ar);
         lOk = keep(lv, lr);
         if (modelQ.size() > 0) void'(modelQ.pop_front());
         if (ready) begin
            if (aOk) begin e.r = ar; e.d = ad; modelQ.push_back(e); sbQ.push_back(e); end
            if (lOk) begin e.r = lr; e.d = ld; modelQ.push_back(e); sbQ.push_back(e); end
         end else if (aOk || lOk) begin
            modelOvf = 1'b1;
         end
      end
      @(negedge clk);
      checkState();
   endtask

   task automatic idle(input int n, input logic [3:0] s1, input logic [3:0] s2);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0, 0, s1, s2);
   endtask

   // Write-port monitor: every issued write must match the oldest accepted entry.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (WriteReg === 1'b1) begin
            if (sbQ.size() == 0) begin
               nCmp++;
               nErr++;
               $display("FAIL wr_unexpected: got write (%0d,0x%0h) expected none", DstReg, DstData);
            end else begin
               e = sbQ.pop_front();
               chk("wr_reg", 32'(DstReg), 32'(e.r));
               chk("wr_data", 32'(DstData), 32'(e.d));
            end
         end
      end
   end

   initial begin
      // T1 reset
      cycle(0, 0, 0, 0, 0, 0, 0, 4'd1, 4'd2);
      cycle(0, 0, 0, 0, 0, 0, 0, 4'd1, 4'd2);
      chk("t1_in_ready", 32'(in_ready), 32'd1);
      // T2 single ALU write
      cycle(1, 1, 4'd3, 16'h1234, 0, 0, 0, 4'd3, 4'd0);
      chk("t2_dstreg", 32'(DstReg), 32'd3);
      chk("t2_dstdata", 32'(DstData), 32'h1234);
      idle(2, 4'd3, 4'd1);
      // T3 ALU + load same cycle
      cycle(1, 1, 4'd1, 16'hAAAA, 1, 4'd2, 16'h5555, 4'd2, 4'd1);
      idle(3, 4'd1, 4'd2);
      // T4 three back-to-back pairs, third dropped
      cycle(1, 1, 4'd1, 16'd1, 1, 4'd2, 16'd2, 4'd1, 4'd2);
      cycle(1, 1, 4'd3, 16'd3, 1, 4'd4, 16'd4, 4'd3, 4'd4);
      cycle(1, 1, 4'd5, 16'd5, 1, 4'd6, 16'd6, 4'd5, 4'd6);
      chk("t4_err_ovf", 32'(err_ovf), 32'd1);
      idle(5, 4'd4, 4'd6);
      // T5 youngest-match forwarding with two R5 writes pending
      cycle(1, 1, 4'd9, 16'h0009, 1, 4'd5, 16'h0001, 4'd5, 4'd6);
      cycle(1, 1, 4'd5, 16'h0002, 1, 4'd7, 16'h0007, 4'd5, 4'd6);
      chk("t5_hit1", 32'(fwd_hit1), 32'd1);
      chk("t5_data1", 32'(fwd_data1), 32'h0002);
      chk("t5_hit2", 32'(fwd_hit2), 32'd0);
      idle(5, 4'd5, 4'd7);
      // T6 register 0
      cycle(1, 1, 4'd0, 16'hFFFF, 0, 0, 0, 4'd0, 4'd0);
      idle(2, 4'd0, 4'd0);
      // T7 reset with entries pending
      cycle(1, 1, 4'd10, 16'hA0A0, 1, 4'd11, 16'hB1B1, 4'd10, 4'd11);
      cycle(1, 1, 4'd12, 16'hC2C2, 1, 4'd13, 16'hD3D3, 4'd12, 4'd13);
      cycle(0, 0, 0, 0, 0, 0, 0, 4'd12, 4'd13);
      chk("t7_count", 32'(count), 32'd0);
      idle(3, 4'd12, 4'd13);
      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 63) != 0),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      idle(8, 4'd0, 4'd1);
      chk("sb_drained", 32'(sbQ.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
